// File: rtl/cga_attrib_pkg.sv
// Shared types and sizes for the CGA/Tandy attribute/colour composer.
package cga_attrib_pkg;

  localparam int IDX_W     = 4;
  localparam int PAL_DEPTH = 16;

  typedef enum logic [1:0] {
    TXT_FG = 2'd0,
    TXT_BG = 2'd1,
    GFX    = 2'd2,
    BORDER = 2'd3
  } sel_e;

endpackage

// File: rtl/cga_blink_div.sv
// Character blink divider: edge-detects the blink square wave on every clk and
// toggles blink_phase every BLINK_DIV rising edges, advancing only on ce.
module cga_blink_div #(
  parameter int BLINK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic blink,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [1:0]       blink_sr;
  logic             rise;
  logic             edge_pend;
  logic [CNT_W-1:0] cnt;

  assign rise = (blink_sr == 2'b01);

  // An edge seen while ce is low is remembered so the divider still counts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_sr    <= 2'b00;
      edge_pend   <= 1'b0;
      cnt         <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_sr <= {blink_sr[0], blink};
      if (ce) begin
        edge_pend <= 1'b0;
        if (rise || edge_pend) begin
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end else if (rise) begin
        edge_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cga_attrib_pipe.sv
// CGA/Tandy attribute/colour composer with a 2-stage ce-qualified pipeline.
// Optional palette remap is compiled in with CGA_ATTRIB_PALETTE_EN.
module cga_attrib_pipe
  import cga_attrib_pkg::*;
#(
  parameter int BLINK_DIV = 1,
  parameter int OUT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [7:0]       att_byte,
  input  logic             pix_in,
  input  logic             cursor,
  input  logic             blink,
  input  logic             blink_enabled,
  input  logic             grph_mode,
  input  logic             bw_mode,
  input  logic             mode_640,
  input  logic             tandy_16_mode,
  input  logic             c0,
  input  logic             c1,
  input  logic             pix_640,
  input  logic [3:0]       pix_tandy,
  input  logic [7:0]       cga_color_reg,
  input  logic [4:0]       tandy_bordercol,
  input  logic             display_enable,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             pal_we,
  input  logic [3:0]       pal_addr,
  input  logic [OUT_W-1:0] pal_data,
  output logic [OUT_W-1:0] pix_out,
  output logic             de_out,
  output logic             hs_out,
  output logic             vs_out
);

  logic             blink_phase;
  logic [IDX_W-1:0] att_bg, gfx_idx, border_idx;
  logic             blink_area, alpha, gfx_pix, shutter;
  sel_e             sel;

  cga_blink_div #(.BLINK_DIV(BLINK_DIV)) u_blink_div (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .blink       (blink),
    .blink_phase (blink_phase)
  );

  always_comb begin
    att_bg     = blink_enabled ? {1'b0, att_byte[6:4]} : att_byte[7:4];
    blink_area = ~(blink_enabled & att_byte[7] & ~cursor) | ~blink_phase;
    alpha      = (pix_in & blink_area) | (cursor & blink);
    gfx_pix    = tandy_16_mode | mode_640 | c0 | c1;
    if (!display_enable)          sel = BORDER;
    else if (grph_mode & gfx_pix) sel = GFX;
    else if (grph_mode)           sel = BORDER;
    else if (alpha)               sel = TXT_FG;
    else                          sel = TXT_BG;
    gfx_idx    = tandy_16_mode ? pix_tandy
                               : {cga_color_reg[4], c1, c0, bw_mode ? c0 : cga_color_reg[5]};
    border_idx = tandy_16_mode ? tandy_bordercol[3:0] : cga_color_reg[3:0];
    shutter    = hsync | vsync | (mode_640 & ~(display_enable & pix_640));
  end

  // Stage 1: register the resolved selection and all candidate indices.
  sel_e             sel_p1;
  logic [IDX_W-1:0] fg_p1, bg_p1, gfx_p1, border_p1;
  logic             shutter_p1, de_p1, hs_p1, vs_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_p1     <= TXT_FG;
      fg_p1      <= '0;
      bg_p1      <= '0;
      gfx_p1     <= '0;
      border_p1  <= '0;
      shutter_p1 <= 1'b0;
      de_p1      <= 1'b0;
      hs_p1      <= 1'b0;
      vs_p1      <= 1'b0;
    end else if (ce) begin
      sel_p1     <= sel;
      fg_p1      <= att_byte[3:0];
      bg_p1      <= att_bg;
      gfx_p1     <= gfx_idx;
      border_p1  <= border_idx;
      shutter_p1 <= shutter;
      de_p1      <= display_enable;
      hs_p1      <= hsync;
      vs_p1      <= vsync;
    end
  end

  logic [IDX_W-1:0] idx_p2;
  logic [OUT_W-1:0] mapped;

  always_comb begin
    case (sel_p1)
      TXT_FG:  idx_p2 = fg_p1;
      TXT_BG:  idx_p2 = bg_p1;
      GFX:     idx_p2 = gfx_p1;
      default: idx_p2 = border_p1;
    endcase
  end

`ifdef CGA_ATTRIB_PALETTE_EN
  logic [OUT_W-1:0] pal [PAL_DEPTH];

  // Writes run on every clk; stage 2 samples the pre-write value on a same-clk hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PAL_DEPTH; i++) pal[i] <= OUT_W'(i);
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  assign mapped = pal[idx_p2];
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we, pal_addr, pal_data};
  assign mapped     = OUT_W'(idx_p2);
`endif

  logic unused_bits;
  assign unused_bits = ^{tandy_bordercol[4], cga_color_reg[7:6]};

  // Stage 2: palette map, shutter blanking, delayed syncs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_out <= '0;
      de_out  <= 1'b0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
    end else if (ce) begin
      pix_out <= shutter_p1 ? '0 : mapped;
      de_out  <= de_p1;
      hs_out  <= hs_p1;
      vs_out  <= vs_p1;
    end
  end

endmodule

// File: tb/tb_cga_attrib_pipe.sv
// Directed scoreboard bench for cga_attrib_pipe (BLINK_DIV=2, OUT_W=8).
module tb_cga_attrib_pipe;

  localparam int OUT_W     = 8;
  localparam int BLINK_DIV = 2;
`ifdef CGA_ATTRIB_PALETTE_EN
  localparam logic [OUT_W-1:0] PAL_NEW = 8'hA5;
`else
  localparam logic [OUT_W-1:0] PAL_NEW = 8'h0E;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b1;
  logic [7:0] att_byte = '0;
  logic pix_in = 0, cursor = 0, blink = 0, blink_enabled = 0;
  logic grph_mode = 0, bw_mode = 0, mode_640 = 0, tandy_16_mode = 0;
  logic c0 = 0, c1 = 0, pix_640 = 0;
  logic [3:0] pix_tandy = '0;
  logic [7:0] cga_color_reg = '0;
  logic [4:0] tandy_bordercol = '0;
  logic display_enable = 0, hsync = 0, vsync = 0;
  logic pal_we = 0;
  logic [3:0] pal_addr = '0;
  logic [OUT_W-1:0] pal_data = '0;
  logic [OUT_W-1:0] pix_out;
  logic de_out, hs_out, vs_out;

  always #5 clk = ~clk;

  cga_attrib_pipe #(.BLINK_DIV(BLINK_DIV), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .ce(ce), .att_byte(att_byte), .pix_in(pix_in),
    .cursor(cursor), .blink(blink), .blink_enabled(blink_enabled),
    .grph_mode(grph_mode), .bw_mode(bw_mode), .mode_640(mode_640),
    .tandy_16_mode(tandy_16_mode), .c0(c0), .c1(c1), .pix_640(pix_640),
    .pix_tandy(pix_tandy), .cga_color_reg(cga_color_reg),
    .tandy_bordercol(tandy_bordercol), .display_enable(display_enable),
    .hsync(hsync), .vsync(vsync), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .pix_out(pix_out), .de_out(de_out), .hs_out(hs_out),
    .vs_out(vs_out)
  );

  typedef struct {
    logic [OUT_W-1:0] pix;
    logic de, hs, vs;
    bit   chk;
    int   tag;
  } exp_t;

  exp_t sbq[$];
  exp_t hold;
  bit   hold_ok = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic cmp(input int tag, input string what,
                     input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL step%0d %s: observed %0h expected %0h", tag, what, got, want);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    cmp(e.tag, "pix_out", pix_out, e.pix);
    cmp(e.tag, "de_out", OUT_W'(de_out), OUT_W'(e.de));
    cmp(e.tag, "hs_out", OUT_W'(hs_out), OUT_W'(e.hs));
    cmp(e.tag, "vs_out", OUT_W'(vs_out), OUT_W'(e.vs));
  endtask

  // One clock: push the expectation for the current inputs when ce is high,
  // pop the entry that has reached the output, or check hold when ce is low.
  task automatic tick(input bit chk, input int tag, input logic [OUT_W-1:0] px);
    exp_t e;
    bit   ce_now;
    ce_now = ce;
    if (ce_now) begin
      e.pix = px; e.de = display_enable; e.hs = hsync; e.vs = vsync;
      e.chk = chk; e.tag = tag;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (ce_now) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front();
        if (e.chk) begin
          cmp_all(e);
          hold = e;
          hold_ok = 1;
        end else begin
          hold_ok = 0;
        end
      end
    end else if (hold_ok) begin
      cmp_all(hold);
    end
  endtask

  task automatic blink_pulse();
    blink = 1'b1;
    repeat (3) tick(0, 0, '0);
    blink = 1'b0;
    repeat (3) tick(0, 0, '0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    cmp(0, "reset pix_out", pix_out, '0);
    cmp(0, "reset de_out", OUT_W'(de_out), '0);
    cmp(0, "reset hs_out", OUT_W'(hs_out), '0);
    cmp(0, "reset vs_out", OUT_W'(vs_out), '0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Text foreground/background
    display_enable = 1; att_byte = 8'h1E;
    pix_in = 1; tick(1, 1, 8'h0E);
    pix_in = 0; tick(1, 2, 8'h01);

    // Graphics
    grph_mode = 1; cga_color_reg = 8'h30;
    c1 = 1; c0 = 0; tick(1, 3, 8'h0D);
    c1 = 0; c0 = 0; tick(1, 4, 8'h00);
    cga_color_reg = 8'h37; tick(1, 5, 8'h07);
    c1 = 1; hsync = 1; tick(1, 6, 8'h00);
    hsync = 0; cga_color_reg = 8'h17; c1 = 0; c0 = 1; tick(1, 7, 8'h0A);
    bw_mode = 1; tick(1, 8, 8'h0B);
    display_enable = 0; tick(1, 9, 8'h07);
    display_enable = 1; bw_mode = 0; tandy_16_mode = 1; pix_tandy = 4'h9; tick(1, 10, 8'h09);
    display_enable = 0; tandy_bordercol = 5'h1C; tick(1, 11, 8'h0C);
    display_enable = 1; tandy_16_mode = 0; mode_640 = 1; c0 = 0; pix_640 = 1; tick(1, 12, 8'h08);
    pix_640 = 0; tick(1, 13, 8'h00);
    mode_640 = 0; grph_mode = 0; c0 = 0; c1 = 0;

    // Blink
    blink_enabled = 1; att_byte = 8'h9E; pix_in = 1; tick(1, 14, 8'h0E);
    blink_pulse(); blink_pulse();
    tick(1, 15, 8'h01);
    cursor = 1; tick(1, 16, 8'h0E);
    cursor = 0; tick(1, 17, 8'h01);
    blink_pulse(); blink_pulse();
    tick(1, 18, 8'h0E);
    blink_enabled = 0; pix_in = 0; tick(1, 19, 8'h09);

    // ce pulsed every third clock
    att_byte = 8'h1E;
    pix_in = 1;                          ce = 1; tick(1, 20, 8'h0E); ce = 0; repeat (2) tick(0, 20, '0);
    pix_in = 0;                          ce = 1; tick(1, 21, 8'h01); ce = 0; repeat (2) tick(0, 21, '0);
    pix_in = 1; hsync = 1;               ce = 1; tick(1, 22, 8'h00); ce = 0; repeat (2) tick(0, 22, '0);
    hsync = 0; vsync = 1;                ce = 1; tick(1, 23, 8'h00); ce = 0; repeat (2) tick(0, 23, '0);
    vsync = 0; display_enable = 0; cga_color_reg = 8'h05;
                                         ce = 1; tick(1, 24, 8'h05); ce = 0; repeat (2) tick(0, 24, '0);
    display_enable = 1;                  ce = 1; tick(1, 25, 8'h0E); ce = 0; repeat (2) tick(0, 25, '0);
    ce = 1;

    // Palette write colliding with a stage-2 read of the same entry
    tick(1, 26, 8'h0E);
    pal_we = 1; pal_addr = 4'hE; pal_data = 8'hA5;
    tick(1, 27, PAL_NEW);
    pal_we = 0;
    tick(1, 28, PAL_NEW);
    tick(1, 29, PAL_NEW);
    tick(0, 0, '0);

    // Asynchronous reset between clocks
    #2 reset = 1'b1;
    #1;
    cmp(30, "midreset pix_out", pix_out, '0);
    cmp(30, "midreset de_out", OUT_W'(de_out), '0);
    sbq.delete();
    hold_ok = 0;
    #1 reset = 1'b0;
    tick(1, 31, 8'h0E);
    cmp(31, "first ce after reset pix_out", pix_out, '0);
    tick(1, 32, 8'h0E);
    tick(0, 0, '0);
    tick(0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
